// File: rtl/seq_pkg.sv
// Shared definitions for the 1001 pattern link: FSM encodings and the default
// pattern constant also used by the detector side.
package seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam int unsigned SEQ_PAT_W = 4;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PAT = 4'b1001;

endpackage

// File: rtl/pat_tracker.sv
// Tracks the last PAT_W-1 emitted bits of the current frame and counts
// overlapping PAT matches with a saturating counter.
module pat_tracker
  import seq_pkg::*;
#(
  parameter int unsigned PAT_W = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PAT = PAT_W'(SEQ_PAT),
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             arm,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  logic [PAT_W-2:0] hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PAT_W-1:0] win;

  always_comb begin
    hist_d = hist_q;
    cnt_d  = cnt_q;
    win    = {hist_q, bit_in};
    if (clear) begin
      hist_d = '0;
      cnt_d  = '0;
    end else if (shift) begin
      hist_d = win[PAT_W-2:0];
      // arm gates out windows that still contain cleared (not emitted) history bits
      if (arm && (win == PAT) && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      cnt_q  <= '0;
    end else begin
      hist_q <= hist_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    count = cnt_q;
  end

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: loads a word on load/ready, shifts it out MSB
// first on x, pulses done after the last bit and reports PAT matches per frame.
module seq_gen
  import seq_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PAT_W  = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PAT = PAT_W'(SEQ_PAT),
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
  output logic              ready,
  output logic              x,
  output logic              x_valid,
  output logic              done,
  output logic [CNT_W-1:0]  pat_cnt
);

  localparam int unsigned CW = $clog2(DATA_W);
  localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);
  localparam logic [CW-1:0] ARM_MAX  = CW'(DATA_W - PAT_W);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              trk_clear, trk_shift, trk_arm;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    trk_clear = 1'b0;
    trk_shift = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shreg_d   = din;
          cnt_d     = LAST_IDX;
          trk_clear = 1'b1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
        trk_shift = 1'b1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Emitted bits including the current one are DATA_W - cnt_q.
  always_comb begin
    ready   = (state_q == S_IDLE);
    x_valid = (state_q == S_SHIFT);
    done    = (state_q == S_DONE);
    x       = x_valid & shreg_q[DATA_W-1];
    trk_arm = (cnt_q <= ARM_MAX);
  end

  pat_tracker #(
    .PAT_W (PAT_W),
    .PAT   (PAT),
    .CNT_W (CNT_W)
  ) u_pat_tracker (
    .clk    (clk),
    .rst    (rst),
    .clear  (trk_clear),
    .shift  (trk_shift),
    .arm    (trk_arm),
    .bit_in (x),
    .count  (pat_cnt)
  );

endmodule
